snake_game_ctrl: RTL and testbench

- Game sequencer for the snake display path. Runs on the same fast clock as the graphics unit.
- Turns raw direction buttons and the VGA v_sync into frame-paced snake head moves, tracks game state (idle/play/dead) and score.
- Presents head position and a one-cycle move strobe to the graphics/body-memory logic, which answer with food-hit and self-collision flags.

---
 rtl/snake_game_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// snake_game_ctrl
// Game sequencer for the snake display path. It synchronises the raw buttons
// and VGA v_sync, paces head moves off frame ticks, tracks the game state
// (IDLE / PLAY / DEAD) and the score.
//
// Ports
//   clk          system clock (shared with the graphics unit)
//   reset        asynchronous, active-low reset
//   up/down/left/right  raw button levels, asynchronous, active-high
//   v_sync       VGA vertical sync (active-low pulse), asynchronous
//   food_hit     head cell == food cell, valid the cycle after move_strobe
//   body_hit     head overlaps body, valid the cycle after move_strobe
//   head_x/head_y  head cell (column 0..GRID_W-1, row 0..GRID_H-1)
//   dir          current direction: 0 up, 1 down, 2 left, 3 right
//   move_strobe  one-cycle pulse when head_x/head_y change
//   grow         one-cycle pulse: lengthen the body by one
//   game_state   0 IDLE, 1 PLAY, 2 DEAD (also serves as the FSM debug view)
//   score        food eaten this game, saturating
//
// Move/hit handshake: move_strobe is high for exactly one cycle with the new
// head cell already on head_x/head_y. The graphics and body memory answer
// with food_hit/body_hit in the following cycle only; those inputs are
// ignored in every other cycle.
// ---------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int GRID_W          = 40,
    parameter int GRID_H          = 30,
    parameter int FRAMES_PER_MOVE = 8,
    parameter int DEAD_FRAMES     = 60,
    parameter int SCORE_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               v_sync,
    input  logic               food_hit,
    input  logic               body_hit,
    output logic [5:0]         head_x,
    output logic [4:0]         head_y,
    output logic [1:0]         dir,
    output logic               move_strobe,
    output logic               grow,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] score
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    localparam int FW = (FRAMES_PER_MOVE > 1) ? $clog2(FRAMES_PER_MOVE) : 1;
    localparam int DW = $clog2(DEAD_FRAMES + 1);
    localparam logic [5:0]    CENTRE_X   = 6'(GRID_W / 2);
    localparam logic [4:0]    CENTRE_Y   = 5'(GRID_H / 2);
    localparam logic [5:0]    LAST_X     = 6'(GRID_W - 1);
    localparam logic [4:0]    LAST_Y     = 5'(GRID_H - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_MOVE - 1);
    localparam logic [DW-1:0] DEAD_LAST  = DW'(DEAD_FRAMES);

    state_e state_q, state_d;

    // button vectors are ordered {up, down, left, right}
    logic [3:0]         btn_meta_q, btn_sync_q;
    logic               vs_meta_q, vs_sync_q, vs_prev_q;
    logic [5:0]         head_x_q, head_x_d;
    logic [4:0]         head_y_q, head_y_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         pending_q, pending_d;
    logic               strobe_q, strobe_d;
    logic               grow_q, grow_d;
    logic               eval_q, eval_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [FW-1:0]      frame_cnt_q, frame_cnt_d;
    logic [DW-1:0]      dead_cnt_q, dead_cnt_d;
    logic               idle_seen_q, idle_seen_d;
    logic               press_q, press_d;

    logic       frame_tick, any_btn, move_tick, blocked, dead_done;
    logic [1:0] sel_dir;
    logic [5:0] next_x;
    logic [4:0] next_y;

    assign frame_tick = vs_prev_q & ~vs_sync_q;
    assign any_btn    = |btn_sync_q;
    assign move_tick  = (state_q == ST_PLAY) && frame_tick && (frame_cnt_q == FRAME_LAST);
    assign dead_done  = (dead_cnt_q == DEAD_LAST);

    // fixed priority up > down > left > right
    always_comb begin
        sel_dir = 2'd3;
        if (btn_sync_q[3])      sel_dir = 2'd0;
        else if (btn_sync_q[2]) sel_dir = 2'd1;
        else if (btn_sync_q[1]) sel_dir = 2'd2;
    end

    // the edge check happens before any arithmetic so nothing ever wraps
    always_comb begin
        blocked = 1'b0;
        next_x  = head_x_q;
        next_y  = head_y_q;
        case (pending_q)
            2'd0:    begin blocked = (head_y_q == 5'd0);   next_y = head_y_q - 5'd1; end
            2'd1:    begin blocked = (head_y_q == LAST_Y); next_y = head_y_q + 5'd1; end
            2'd2:    begin blocked = (head_x_q == 6'd0);   next_x = head_x_q - 6'd1; end
            default: begin blocked = (head_x_q == LAST_X); next_x = head_x_q + 6'd1; end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_btn) state_d = ST_PLAY;
            ST_PLAY: if ((move_tick && blocked) || (eval_q && body_hit)) state_d = ST_DEAD;
            ST_DEAD: if (dead_done && press_q && !any_btn) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // output / datapath next values
    always_comb begin
        head_x_d    = head_x_q;
        head_y_d    = head_y_q;
        dir_d       = dir_q;
        pending_d   = pending_q;
        strobe_d    = 1'b0;
        grow_d      = 1'b0;
        eval_d      = strobe_q;
        score_d     = score_q;
        frame_cnt_d = frame_cnt_q;
        dead_cnt_d  = '0;
        idle_seen_d = 1'b0;
        press_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                head_x_d    = CENTRE_X;
                head_y_d    = CENTRE_Y;
                score_d     = '0;
                frame_cnt_d = '0;
                if (any_btn) begin
                    dir_d     = sel_dir;
                    pending_d = sel_dir;
                end
            end
            ST_PLAY: begin
                // reverse test is against the committed dir, not pending_dir
                if (any_btn && (sel_dir != (dir_q ^ 2'b01))) pending_d = sel_dir;
                if (frame_tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        dir_d       = pending_q;
                        if (!blocked) begin
                            head_x_d = next_x;
                            head_y_d = next_y;
                            strobe_d = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                    end
                end
                // body_hit wins over food_hit
                if (eval_q && food_hit && !body_hit) begin
                    grow_d = 1'b1;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                end
            end
            ST_DEAD: begin
                dead_cnt_d  = dead_cnt_q;
                idle_seen_d = idle_seen_q;
                press_d     = press_q;
                if (frame_tick && !dead_done) dead_cnt_d = dead_cnt_q + DW'(1);
                // restart needs all-released, then a press, then all-released
                if (dead_done) begin
                    if (!any_btn) idle_seen_d = 1'b1;
                    if (idle_seen_q && any_btn) press_d = 1'b1;
                end
                if (state_d == ST_IDLE) begin
                    head_x_d = CENTRE_X;
                    head_y_d = CENTRE_Y;
                    score_d  = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            vs_meta_q   <= 1'b0;
            vs_sync_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            head_x_q    <= CENTRE_X;
            head_y_q    <= CENTRE_Y;
            dir_q       <= 2'd3;
            pending_q   <= 2'd3;
            strobe_q    <= 1'b0;
            grow_q      <= 1'b0;
            eval_q      <= 1'b0;
            score_q     <= '0;
            frame_cnt_q <= '0;
            dead_cnt_q  <= '0;
            idle_seen_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            btn_meta_q  <= {up, down, left, right};
            btn_sync_q  <= btn_meta_q;
            vs_meta_q   <= v_sync;
            vs_sync_q   <= vs_meta_q;
            vs_prev_q   <= vs_sync_q;
            head_x_q    <= head_x_d;
            head_y_q    <= head_y_d;
            dir_q       <= dir_d;
            pending_q   <= pending_d;
            strobe_q    <= strobe_d;
            grow_q      <= grow_d;
            eval_q      <= eval_d;
            score_q     <= score_d;
            frame_cnt_q <= frame_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
            idle_seen_q <= idle_seen_d;
            press_q     <= press_d;
        end
    end

    assign head_x      = head_x_q;
    assign head_y      = head_y_q;
    assign dir         = dir_q;
    assign move_strobe = strobe_q;
    assign grow        = grow_q;
    assign game_state  = state_q;
    assign score       = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_game_ctrl
// Bench for snake_game_ctrl. A behavioural model tracks the snake as plain
// integers (position, direction, score, game phase) and pushes the expected
// move/grow events into exp_q; a monitor pops and compares whenever the DUT
// raises move_strobe or grow. A responder answers each strobe with the
// food/body flags planned by the stimulus.
// ---------------------------------------------------------------------------
module tb_snake_game_ctrl;

    localparam int GW = 40;
    localparam int GH = 30;
    localparam int FPM = 8;
    localparam int DEADF = 60;
    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_DEAD = 2;
    localparam int W = 22;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic v_sync = 1'b1, food_hit = 1'b0, body_hit = 1'b0;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [1:0] dir;
    logic       move_strobe, grow;
    logic [1:0] game_state;
    logic [7:0] score;

    snake_game_ctrl dut (
        .clk(clk), .reset(reset),
        .up(up), .down(down), .left(left), .right(right),
        .v_sync(v_sync), .food_hit(food_hit), .body_hit(body_hit),
        .head_x(head_x), .head_y(head_y), .dir(dir),
        .move_strobe(move_strobe), .grow(grow),
        .game_state(game_state), .score(score)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];   // {kind(1: grow), score(8), dir(2), y(5), x(6)}

    // model of the game
    int m_x, m_y, m_dir, m_pend, m_score, m_state, m_frames;
    bit plan_food = 1'b0, plan_body = 1'b0;
    int stray_req = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [W-1:0] pack_ev(input int kind, input int x, input int y,
                                             input int d, input int s);
        return {1'(kind), 8'(s), 2'(d), 5'(y), 6'(x)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset && (move_strobe || grow)) begin
            logic [W-1:0] e;
            if (move_strobe && grow) begin
                checks++; failures++;
                $display("FAIL strobe_grow_exclusive: both high");
            end
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_event: strobe=%0d grow=%0d, none expected", move_strobe, grow);
            end else begin
                e = exp_q.pop_front();
                check("event_kind(0=strobe,1=grow)", move_strobe ? 0 : 1, int'(e[21]));
                if (e[21] == 1'b0) begin
                    check("strobe_head_x", head_x, int'(e[5:0]));
                    check("strobe_head_y", head_y, int'(e[10:6]));
                    check("strobe_dir", dir, int'(e[12:11]));
                end else begin
                    check("grow_score", score, int'(e[20:13]));
                end
            end
        end
    end

    // ---------------- responder ----------------
    initial begin
        int stray_seen;
        bit f, b;
        stray_seen = 0;
        forever begin
            @(negedge clk);
            if (move_strobe) begin
                f = plan_food;
                b = plan_body;
                @(posedge clk); #1 food_hit = f; body_hit = b;
                @(posedge clk); #1 food_hit = 1'b0; body_hit = 1'b0;
            end else if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                @(posedge clk); #1 food_hit = 1'b1;
                @(posedge clk); #1 food_hit = 1'b0;
            end
        end
    end

    // ---------------- driver tasks / model ----------------
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: down = v;
            2: left = v;
            default: right = v;
        endcase
    endtask

    task automatic model_press(input int b);
        if (m_state == M_PLAY) begin
            if (b != (m_dir ^ 1)) m_pend = b;
        end else if (m_state == M_IDLE) begin
            m_dir = b; m_pend = b; m_state = M_PLAY; m_frames = 0;
        end
    endtask

    task automatic model_restart();
        m_state = M_IDLE; m_x = GW / 2; m_y = GH / 2; m_score = 0;
    endtask

    task automatic model_move();
        int nx, ny;
        m_dir = m_pend;
        nx = m_x; ny = m_y;
        case (m_dir)
            0: ny = ny - 1;
            1: ny = ny + 1;
            2: nx = nx - 1;
            default: nx = nx + 1;
        endcase
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            m_state = M_DEAD;
        end else begin
            m_x = nx; m_y = ny;
            exp_q.push_back(pack_ev(0, m_x, m_y, m_dir, 0));
            if (plan_body) m_state = M_DEAD;
            else if (plan_food) begin
                if (m_score < 255) m_score++;
                exp_q.push_back(pack_ev(1, 0, 0, 0, m_score));
            end
        end
    endtask

    task automatic press(input int b);
        model_press(b);
        set_btn(b, 1'b1);
        repeat (4) @(posedge clk);
        #1 set_btn(b, 1'b0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic frame();
        if (m_state == M_PLAY) begin
            m_frames++;
            if (m_frames == FPM) begin
                m_frames = 0;
                model_move();
            end
        end
        v_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1 v_sync = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic period();
        repeat (FPM) frame();
    endtask

    task automatic check_state(input string name);
        check(name, game_state, m_state);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_head_x"}, head_x, 20);
        check({tag, "_head_y"}, head_y, 15);
        check({tag, "_dir"}, dir, 3);
        check({tag, "_move_strobe"}, move_strobe, 0);
        check({tag, "_grow"}, grow, 0);
        check({tag, "_game_state"}, game_state, 0);
        check({tag, "_score"}, score, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int b, score_before;
        bit seen;
        m_x = 20; m_y = 15; m_dir = 3; m_pend = 3; m_score = 0; m_state = M_IDLE; m_frames = 0;

        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // ---- game 1: start, reverse press ignored, run up into the wall ----
        press(3);
        check_state("start_state");
        check("start_dir", dir, 3);
        period();                       // -> (21,15)
        model_press(2);                 // left is the reverse of right
        left = 1'b1;
        period();
        left = 1'b0;
        period();
        press(0);
        for (int i = 0; i < 15; i++) begin
            plan_food = (i == 1 || i == 4 || i == 8);
            period();
            plan_food = 1'b0;
            if (i == 2) begin
                stray_req++;
                repeat (8) @(posedge clk);
                #1 check("stray_food_score", score, m_score);
            end
        end
        check("score_after_food", score, 3);
        check("head_y_at_top", head_y, 0);
        model_press(0);
        up = 1'b1;                      // held from before death
        period();                       // wall: no strobe, DEAD
        check_state("wall_dead_state");
        check("wall_head_y", head_y, 0);
        check("wall_head_x", head_x, m_x);
        check("wall_no_strobe_queue", exp_q.size(), 0);
        repeat (DEADF) frame();
        check_state("held_button_dead");
        up = 1'b0;
        repeat (8) @(posedge clk);
        #1 check_state("release_only_dead");
        press(3);
        model_restart();
        check_state("restart1_state");
        check("restart1_x", head_x, m_x);
        check("restart1_y", head_y, m_y);
        check("restart1_score", score, m_score);

        // ---- game 2: random play, then simultaneous food+body hit ----
        press(3);
        for (int i = 0; i < 12; i++) begin
            b = $urandom_range(0, 4);
            if (b < 4) press(b);
            plan_food = ($urandom_range(0, 2) == 0);
            period();
            plan_food = 1'b0;
        end
        check_state("random_play_state");
        check("random_score", score, m_score);
        score_before = m_score;
        plan_food = 1'b1;
        plan_body = 1'b1;
        period();
        plan_food = 1'b0;
        plan_body = 1'b0;
        check_state("body_hit_state");
        check("body_hit_score", score, score_before);
        check("body_hit_queue", exp_q.size(), 0);
        repeat (DEADF - 1) frame();
        press(0);
        check_state("early_press_dead");
        frame();
        press(1);
        model_restart();
        check_state("restart2_state");
        check("restart2_x", head_x, 20);
        check("restart2_y", head_y, 15);
        check("restart2_score", score, 0);

        // ---- game 3: asynchronous reset right after a move ----
        press(3);
        repeat (FPM - 1) frame();
        m_dir = m_pend;
        m_x = m_x + 1;
        exp_q.push_back(pack_ev(0, m_x, m_y, m_dir, 0));
        plan_food = 1'b1;               // a grow would follow if not reset
        v_sync = 1'b0;
        repeat (2) @(posedge clk);
        #1 v_sync = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (move_strobe) begin
                seen = 1'b1;
                break;
            end
        end
        check("reset_test_strobe_seen", seen, 1);
        #1 reset = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (10) @(posedge clk);
        #1 plan_food = 1'b0;
        reset = 1'b1;
        model_restart();
        m_dir = 3; m_pend = 3;
        repeat (20) @(posedge clk);
        #1 check_state("post_reset_state");
        check("post_reset_score", score, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
